ahb_gpio_bank: RTL



---
 rtl/gpio_pkg.sv | 44 ++++
 rtl/gpio_sync.sv | 34 +++
 rtl/ahb_gpio_bank.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the AHB GPIO bank: register offsets, AHB encodings,
// data-phase states and the byte-lane mask helper.
package gpio_pkg;

    localparam logic [4:0] REG_DATA_IN  = 5'h00;
    localparam logic [4:0] REG_DATA_OUT = 5'h04;
    localparam logic [4:0] REG_DIR      = 5'h08;
    localparam logic [4:0] REG_OUT_SET  = 5'h0C;
    localparam logic [4:0] REG_OUT_CLR  = 5'h10;
    localparam logic [4:0] REG_OUT_TGL  = 5'h14;
    localparam logic [4:0] REG_IRQ_EN   = 5'h18;
    localparam logic [4:0] REG_IRQ_STAT = 5'h1C;

    localparam int PORT_STRIDE = 32'h20;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DP_OKAY = 2'd0,
        DP_ERR1 = 2'd1,
        DP_ERR2 = 2'd2
    } dp_state_e;

    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr;
            HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Per-bit input synchroniser followed by a history stage; flags edges on the
// synchronised value.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STAGES     = 2,
    parameter int BOTH_EDGES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_stage [STAGES];
    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
            r_hist <= '0;
        end else begin
            r_stage[0] <= i_pin;
            for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
            r_hist <= r_stage[STAGES-1];
        end
    end

    assign o_sync = r_stage[STAGES-1];
    assign o_edge = (o_sync & ~r_hist) | ((BOTH_EDGES != 0) ? (~o_sync & r_hist) : '0);

endmodule

// File: rtl/ahb_gpio_bank.sv
// AHB-Lite GPIO slave: N_PORTS ports with direction, atomic set/clear/toggle,
// synchronised inputs and edge interrupts with sticky W1C status.
module ahb_gpio_bank
    import gpio_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
    parameter int                    N_PORTS        = 2,
    parameter int                    PORT_WIDTH     = 16,
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    IRQ_BOTH_EDGES = 0
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [ADDR_WIDTH-1:0]         haddr,
    input  logic [DATA_WIDTH-1:0]         hwdata,
    output logic [DATA_WIDTH-1:0]         hrdata,
    input  logic                          hwrite,
    input  logic                          hsel,
    input  logic [1:0]                    htrans,
    input  logic [2:0]                    hsize,
    output logic                          hready,
    output logic                          hresp,
    input  logic [N_PORTS*PORT_WIDTH-1:0] gpio_in,
    output logic [N_PORTS*PORT_WIDTH-1:0] gpio_out,
    output logic [N_PORTS*PORT_WIDTH-1:0] gpio_oe,
    output logic                          irq
);

    dp_state_e r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] w_off;
    logic [2:0]            w_port;
    logic [4:0]            w_reg;
    logic [3:0]            w_bmask;
    logic                  w_in_range, w_accept, w_xfer, w_err;

    logic                  r_wr_vld_p1;
    logic [2:0]            r_port_p1;
    logic [4:0]            r_reg_p1;
    logic [3:0]            r_bmask_p1;
    logic [DATA_WIDTH-1:0] r_hrdata, w_rdata, w_lane;
    logic [PORT_WIDTH-1:0] w_wbits, w_keep;
    logic                  r_irq, w_irq_any;

    logic [PORT_WIDTH-1:0] r_dout [N_PORTS], r_dir [N_PORTS], r_ien [N_PORTS], r_stat [N_PORTS];
    logic [PORT_WIDTH-1:0] w_dout_nxt [N_PORTS], w_dir_nxt [N_PORTS];
    logic [PORT_WIDTH-1:0] w_ien_nxt [N_PORTS], w_stat_nxt [N_PORTS];
    logic [PORT_WIDTH-1:0] w_sync [N_PORTS], w_edge [N_PORTS];

    // Address phase: decode and qualify; new requests are ignored while stalling in ERR1
    assign w_off      = haddr - START_ADDR;
    assign w_port     = w_off[7:5];
    assign w_reg      = {w_off[4:2], 2'b00};
    assign w_bmask    = byte_mask(hsize, w_off[1:0]);
    assign w_in_range = w_off < ADDR_WIDTH'(N_PORTS * PORT_STRIDE);
    assign w_accept   = (r_state != DP_ERR1);
    assign w_xfer     = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && w_accept;
    assign w_err      = !w_in_range
                     || (hwrite && w_reg == REG_DATA_IN)
                     || (hsize > HSIZE_WORD)
                     || (hsize == HSIZE_HALF && w_off[0])
                     || (hsize == HSIZE_WORD && w_off[1:0] != 2'b00);

    // Data phase: write data lanes; unselected lanes contribute zero
    assign w_lane  = {{8{r_bmask_p1[3]}}, {8{r_bmask_p1[2]}}, {8{r_bmask_p1[1]}}, {8{r_bmask_p1[0]}}};
    assign w_wbits = PORT_WIDTH'(hwdata & w_lane);
    assign w_keep  = PORT_WIDTH'(w_lane);

    genvar gp;
    generate
        for (gp = 0; gp < N_PORTS; gp++) begin : g_port
            gpio_sync #(
                .WIDTH      (PORT_WIDTH),
                .STAGES     (SYNC_STAGES),
                .BOTH_EDGES (IRQ_BOTH_EDGES)
            ) u_sync (
                .i_clk   (HCLK),
                .i_rst_n (HRESETn),
                .i_pin   (gpio_in[gp*PORT_WIDTH +: PORT_WIDTH]),
                .o_sync  (w_sync[gp]),
                .o_edge  (w_edge[gp])
            );
            assign gpio_out[gp*PORT_WIDTH +: PORT_WIDTH] = r_dout[gp] & r_dir[gp];
            assign gpio_oe[gp*PORT_WIDTH +: PORT_WIDTH]  = r_dir[gp];
        end
    endgenerate

    always_comb begin
        w_irq_any = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_dout_nxt[p] = r_dout[p];
            w_dir_nxt[p]  = r_dir[p];
            w_ien_nxt[p]  = r_ien[p];
            w_stat_nxt[p] = r_stat[p];
            if (r_wr_vld_p1 && r_port_p1 == 3'(p)) begin
                case (r_reg_p1)
                    REG_DATA_OUT: w_dout_nxt[p] = (r_dout[p] & ~w_keep) | w_wbits;
                    REG_DIR:      w_dir_nxt[p]  = (r_dir[p] & ~w_keep) | w_wbits;
                    REG_OUT_SET:  w_dout_nxt[p] = r_dout[p] | w_wbits;
                    REG_OUT_CLR:  w_dout_nxt[p] = r_dout[p] & ~w_wbits;
                    REG_OUT_TGL:  w_dout_nxt[p] = r_dout[p] ^ w_wbits;
                    REG_IRQ_EN:   w_ien_nxt[p]  = (r_ien[p] & ~w_keep) | w_wbits;
                    REG_IRQ_STAT: w_stat_nxt[p] = r_stat[p] & ~w_wbits;
                    default: ;
                endcase
            end
            // Edge set is OR-ed after the W1C so a coincident edge wins
            w_stat_nxt[p] = w_stat_nxt[p] | (w_edge[p] & r_ien[p]);
            w_irq_any     = w_irq_any | (|(r_stat[p] & r_ien[p]));
        end
    end

    // Read data comes from next-state values so a read right behind a write sees it
    always_comb begin
        w_rdata = '0;
        if (w_xfer && !hwrite && !w_err) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (w_port == 3'(p)) begin
                    case (w_reg)
                        REG_DATA_IN:  w_rdata = DATA_WIDTH'(w_sync[p]);
                        REG_DATA_OUT: w_rdata = DATA_WIDTH'(w_dout_nxt[p]);
                        REG_DIR:      w_rdata = DATA_WIDTH'(w_dir_nxt[p]);
                        REG_IRQ_EN:   w_rdata = DATA_WIDTH'(w_ien_nxt[p]);
                        REG_IRQ_STAT: w_rdata = DATA_WIDTH'(w_stat_nxt[p]);
                        default:      w_rdata = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) r_state <= DP_OKAY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        hready      = 1'b1;
        hresp       = HRESP_OKAY;
        case (r_state)
            DP_OKAY: if (w_xfer && w_err) w_state_nxt = DP_ERR1;
            DP_ERR1: begin
                hready      = 1'b0;
                hresp       = HRESP_ERROR;
                w_state_nxt = DP_ERR2;
            end
            DP_ERR2: begin
                hresp       = HRESP_ERROR;
                w_state_nxt = (w_xfer && w_err) ? DP_ERR1 : DP_OKAY;
            end
            default: w_state_nxt = DP_OKAY;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_wr_vld_p1 <= 1'b0;
            r_port_p1   <= '0;
            r_reg_p1    <= '0;
            r_bmask_p1  <= '0;
            r_hrdata    <= '0;
            r_irq       <= 1'b0;
            for (int p = 0; p < N_PORTS; p++) begin
                r_dout[p] <= '0;
                r_dir[p]  <= '0;
                r_ien[p]  <= '0;
                r_stat[p] <= '0;
            end
        end else begin
            r_wr_vld_p1 <= w_xfer && hwrite && !w_err;
            r_port_p1   <= w_port;
            r_reg_p1    <= w_reg;
            r_bmask_p1  <= w_bmask;
            r_hrdata    <= w_rdata;
            r_irq       <= w_irq_any;
            for (int p = 0; p < N_PORTS; p++) begin
                r_dout[p] <= w_dout_nxt[p];
                r_dir[p]  <= w_dir_nxt[p];
                r_ien[p]  <= w_ien_nxt[p];
                r_stat[p] <= w_stat_nxt[p];
            end
        end
    end

    assign hrdata = r_hrdata;
    assign irq    = r_irq;

endmodule
